fetch_prefetch_buffer: RTL and testbench
========================================

FETCH_PREFETCH_BUFFER -- requirements
Module: fetch_prefetch_buffer

Interface
REQ-001 DEPTH, 4, instruction FIFO entries (power of two, 2..8).
REQ-002 clk  in  1  single clock; all state rising-edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ena  in  1  design enable; low = synchronous flush, no new requests.
REQ-005 mem_req  out  1  request to SPI program-memory reader; held until mem_valid.
REQ-006 mem_addr  out  16  word address of the outstanding request; stable while mem_req high.
REQ-007 mem_valid  in  1  one-cycle pulse: mem_data carries the word for the oldest request.
REQ-008 mem_data  in  16  instruction word returned by the reader.
REQ-009 fetch_addr  in  16  PC value the core currently wants.
REQ-010 instr  out  16  instruction at FIFO head.
REQ-011 instr_valid  out  1  head valid and head address == fetch_addr.
REQ-012 instr_take  in  1  core consumes head this cycle (qualified by instr_valid).

Function
REQ-013 Addressing SHALL be word-based; next sequential address = addr + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-014 Each FIFO entry SHALL store {addr[15:0], data[15:0]}; instr and instr_valid SHALL be combinational from head entry and fetch_addr.
REQ-015 Controller SHALL have states IDLE, FETCH, DRAIN.
REQ-016 IDLE -> FETCH when ena high and FIFO count (including none outstanding) < DEPTH; mem_req=1, mem_addr=next_fetch.
REQ-017 FETCH: on mem_valid, push {mem_addr, mem_data}, next_fetch += 1; re-issue immediately (mem_req stays high) if FIFO not full after push and pop of same cycle, else -> IDLE.
REQ-018 At most one request SHALL be outstanding; mem_addr SHALL not change while mem_req high.
REQ-019 Redirect: when FIFO non-empty and head addr != fetch_addr, or FIFO empty and fetch_addr != next_fetch with no request outstanding, block SHALL flush FIFO and set next_fetch = fetch_addr in the same cycle.
REQ-020 Redirect during FETCH SHALL deassert mem_req next cycle and enter DRAIN; DRAIN discards the next mem_valid, then -> IDLE (refetch from new next_fetch).
REQ-021 Redirect with FIFO empty in FETCH and mem_addr == fetch_addr SHALL NOT flush (the in-flight word is the wanted one).
REQ-022 Simultaneous push and pop SHALL keep count unchanged; pop with instr_valid low SHALL be ignored.
REQ-023 Full FIFO: no request issued; mem_valid in this state cannot occur by construction.
REQ-024 Pop and redirect in the same cycle: redirect wins; popped entry discarded.
REQ-025 ena low: FIFO flushed, instr_valid=0, no new request; an outstanding request SHALL be drained (DRAIN) before IDLE; next_fetch follows fetch_addr.
REQ-026 Latency: from redirect in IDLE, mem_req rises next cycle; instr_valid rises the cycle after mem_valid.

Reset
REQ-027 On rst_n low: state=IDLE, FIFO count=0, rd/wr pointers=0, next_fetch=0x0000, mem_req=0, mem_addr=0x0000, instr_valid=0, instr=0x0000.
REQ-028 Reset mid-FETCH SHALL abandon the request; a later stray mem_valid while IDLE with mem_req low SHALL be ignored.

Structure
REQ-029 State encoding (IDLE/FETCH/DRAIN), DEPTH default and address width 16 SHALL live in the shared defines header.
REQ-030 The FIFO storage/pointer logic SHALL be one sub-module, prefetch_fifo (push, pop, flush, full, empty, head); control FSM in the top.

Verification
REQ-031 Reset, fetch_addr=0x0000, reader 3-cycle latency -> requests 0x0000..0x0003 issued back-to-back, FIFO full, mem_req low; instr=word[0], instr_valid=1.
REQ-032 Sequential consume: instr_take each cycle with fetch_addr incrementing -> steady stream, no duplicate or skipped addresses, count never exceeds 4.
REQ-033 Branch: FIFO holds 0x0010..0x0013, fetch_addr=0x0040 -> flush, instr_valid=0, mem_addr=0x0040 next cycle, instr_valid after its mem_valid.
REQ-034 Branch while 0x0014 in flight -> DRAIN discards 0x0014 data, next request 0x0040, never presented.
REQ-035 Wrap: fetch_addr=0xFFFE -> requests 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-036 rst_n low mid-FETCH then stray mem_valid -> no push, instr_valid=0, all outputs at reset values.

Source files
------------

// File: rtl/fetch_prefetch_buffer_pkg.sv
// fetch_prefetch_buffer_pkg: shared widths, depth, state encoding and entry type
package fetch_prefetch_buffer_pkg;
  localparam int PF_AW    = 16;
  localparam int PF_DW    = 16;
  localparam int PF_DEPTH = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;
  typedef struct packed {
    logic [PF_AW-1:0] addr;
    logic [PF_DW-1:0] data;
  } entry_t;
  function automatic logic [PF_AW-1:0] next_addr(input logic [PF_AW-1:0] a);
    return a + PF_AW'(1);
  endfunction
endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// fetch_prefetch_buffer_if: program-memory reader port plus core fetch port
interface fetch_prefetch_buffer_if;
  import fetch_prefetch_buffer_pkg::*;
  logic             mem_req;
  logic [PF_AW-1:0] mem_addr;
  logic             mem_valid;
  logic [PF_DW-1:0] mem_data;
  logic [PF_AW-1:0] fetch_addr;
  logic [PF_DW-1:0] instr;
  logic             instr_valid;
  logic             instr_take;
  modport master (output mem_req, mem_addr, instr, instr_valid,
                  input  mem_valid, mem_data, fetch_addr, instr_take);
  modport slave  (input  mem_req, mem_addr, instr, instr_valid,
                  output mem_valid, mem_data, fetch_addr, instr_take);
endinterface

// File: rtl/fetch_prefetch_buffer_fifo.sv
// prefetch_fifo: circular buffer of fetched {addr, data} entries with synchronous flush
module prefetch_fifo
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  entry_t                 din_i,
  output entry_t                 head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q;
  // entry storage; contents are only observed through the valid region
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(push_i);
      rd_q  <= rd_q + PW'(pop_i);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  assign head_o  = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: sequential instruction prefetcher with redirect and drain control
module fetch_prefetch_buffer
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     ena,
  fetch_prefetch_buffer_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t           state_q, state_d;
  logic [PF_AW-1:0] next_fetch_q, next_fetch_d;
  entry_t           head, wr_entry;
  logic [CW-1:0]    count;
  logic             full, empty, hit, redirect, flush, push, pop, full_after;
  assign hit        = !empty && head.addr == bus.fetch_addr;
  assign redirect   = empty ? bus.fetch_addr != next_fetch_q : !hit;
  assign flush      = !ena || redirect;
  assign pop        = bus.instr_take && bus.instr_valid;
  assign push       = state_q == FETCH && bus.mem_valid && !flush;
  assign full_after = count == CW'(DEPTH - 1) && !pop;
  assign wr_entry   = '{addr: next_fetch_q, data: bus.mem_data};
  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(flush),
    .din_i  (wr_entry),
    .head_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  // controller state and the address of the next word to request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      next_fetch_q <= '0;
    end else begin
      state_q      <= state_d;
      next_fetch_q <= next_fetch_d;
    end
  // a flush retargets fetching; an in-flight word is drained rather than pushed
  always_comb begin
    next_fetch_d = flush ? bus.fetch_addr : push ? next_addr(next_fetch_q) : next_fetch_q;
    case (state_q)
      IDLE:    state_d = (ena && (flush || !full)) ? FETCH : IDLE;
      FETCH:   state_d = flush ? (bus.mem_valid ? IDLE : DRAIN)
                               : (bus.mem_valid && full_after) ? IDLE : FETCH;
      DRAIN:   state_d = bus.mem_valid ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // request is the FETCH state itself; core sees the head only when it matches the PC
  always_comb begin
    bus.mem_req     = state_q == FETCH;
    bus.mem_addr    = next_fetch_q;
    bus.instr_valid = ena && hit;
    bus.instr       = empty ? '0 : head.data;
  end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: randomized scoreboard bench for the prefetch buffer
module tb_fetch_prefetch_buffer;
  import fetch_prefetch_buffer_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, ena_nxt = 1'b0;
  fetch_prefetch_buffer_if bus();
  fetch_prefetch_buffer dut (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_take = 0, lat_min = 3, lat_max = 3, rd_cnt = 0;
  bit seq_mode = 1'b0, took = 1'b0, busy = 1'b0;
  logic [15:0] salt, req_addr, pc;
  logic [15:0] req_log[$];
  logic [15:0] exp_q[$];

  function automatic logic [15:0] word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // program-memory reader: one request at a time, random latency, word = f(addr)
  initial begin : reader
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_valid = 1'b0;
      if (busy) begin
        if (bus.mem_req === 1'b1) chk("mem_addr_stable", 32'(bus.mem_addr), 32'(req_addr));
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.mem_valid = 1'b1;
          bus.mem_data  = word(req_addr);
          busy = 1'b0;
        end
      end else if (bus.mem_req === 1'b1) begin
        req_addr = bus.mem_addr;
        busy     = 1'b1;
        rd_cnt   = int'($urandom_range(lat_max, lat_min));
        req_log.push_back(req_addr);
        if (seq_mode) chk("inflight_le_depth", 32'(req_log.size() - n_take <= PF_DEPTH), 1);
      end
    end
  end

  // monitor: every consumed instruction must match the queued expectation
  always @(negedge clk)
    if (bus.instr_take === 1'b1 && bus.instr_valid === 1'b1) begin
      n_take++;
      chk("scoreboard_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("instr_data", 32'(bus.instr), 32'(exp_q.pop_front()));
    end

  task automatic core_cycle(input logic [15:0] fa, input bit want);
    @(posedge clk); #1;
    ena = ena_nxt;
    bus.fetch_addr = fa;
    bus.instr_take = 1'b0;
    #1;
    took = want && bus.instr_valid === 1'b1;
    if (took) begin
      bus.instr_take = 1'b1;
      exp_q.push_back(word(fa));
    end
  endtask

  task automatic fetch(input logic [15:0] fa);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      core_cycle(fa, 1'b1);
      ok = took;
    end
    chk("fetch_delivered", 32'(ok), 1);
  endtask

  task automatic quiesce(input logic [15:0] fa);
    ena_nxt = 1'b0;
    repeat (8) core_cycle(fa, 1'b0);
    req_log.delete();
    n_take  = 0;
    ena_nxt = 1'b1;
  endtask

  initial begin : main
    salt = 16'($urandom);
    bus.fetch_addr = '0;
    bus.instr_take = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", 32'(bus.instr), 0);
    rst_n = 1'b1;
    ena_nxt = 1'b1;
    repeat (30) core_cycle(16'h0000, 1'b0);
    chk("fill_count", 32'(req_log.size()), 4);
    foreach (req_log[i]) chk("fill_addr", 32'(req_log[i]), 32'(i));
    chk("full_mem_req", 32'(bus.mem_req), 0);
    chk("full_instr_valid", 32'(bus.instr_valid), 1);
    chk("full_instr", 32'(bus.instr), 32'(word(16'h0000)));

    quiesce(16'h0010);
    repeat (30) core_cycle(16'h0010, 1'b0);
    chk("b_fill_count", 32'(req_log.size()), 4);
    foreach (req_log[i]) chk("b_fill_addr", 32'(req_log[i]), 32'(16 + i));
    req_log.delete();
    core_cycle(16'h0040, 1'b0);
    chk("branch_valid_drop", 32'(bus.instr_valid), 0);
    core_cycle(16'h0040, 1'b0);
    chk("branch_mem_req", 32'(bus.mem_req), 1);
    chk("branch_mem_addr", 32'(bus.mem_addr), 32'h40);
    fetch(16'h0040);

    lat_min = 4; lat_max = 4;
    quiesce(16'h0010);
    repeat (30) core_cycle(16'h0010, 1'b0);
    fetch(16'h0010);
    for (int i = 0; i < 40 && req_log.size() < 5; i++) core_cycle(16'h0011, 1'b0);
    chk("c_inflight_0014", 32'(req_log[$]), 32'h14);
    core_cycle(16'h0040, 1'b0);
    fetch(16'h0040);
    chk("c_refetch_addr", 32'(req_log[5]), 32'h40);

    lat_min = 1; lat_max = 3;
    quiesce(16'h0100);
    seq_mode = 1'b1;
    for (int i = 0; i < 40; i++) fetch(16'(32'h0100 + i));
    seq_mode = 1'b0;
    foreach (req_log[i]) chk("seq_req_addr", 32'(req_log[i]), 32'(16'(32'h0100 + i)));

    lat_min = 2; lat_max = 2;
    quiesce(16'hFFFE);
    repeat (30) core_cycle(16'hFFFE, 1'b0);
    chk("wrap_count", 32'(req_log.size()), 4);
    foreach (req_log[i]) chk("wrap_addr", 32'(req_log[i]), 32'(16'(32'hFFFE + i)));
    for (int i = 0; i < 6; i++) fetch(16'(32'hFFFE + i));

    lat_min = 1; lat_max = 4;
    pc = 16'($urandom);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(19, 0))
        0: pc = 16'($urandom);
        1: pc = 16'($urandom_range(16'hFFFF, 16'hFFFA));
        2: begin
          ena_nxt = 1'b0;
          repeat ($urandom_range(3, 1)) core_cycle(pc, 1'b1);
          ena_nxt = 1'b1;
        end
        3: repeat ($urandom_range(3, 1)) core_cycle(pc, 1'b0);
        default: ;
      endcase
      fetch(pc);
      pc = pc + 16'd1;
    end

    lat_min = 4; lat_max = 4;
    quiesce(16'h0200);
    repeat (2) core_cycle(16'h0200, 1'b0);
    chk("g_req_issued", 32'(busy), 1);
    rst_n = 1'b0; ena = 1'b0; ena_nxt = 1'b0;
    bus.fetch_addr = '0; bus.instr_take = 1'b0;
    #1;
    chk("g_rst_mem_req", 32'(bus.mem_req), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      core_cycle(16'h0000, 1'b1);
      chk("g_instr_valid", 32'(bus.instr_valid), 0);
      chk("g_mem_req", 32'(bus.mem_req), 0);
      chk("g_mem_addr", 32'(bus.mem_addr), 0);
      chk("g_instr", 32'(bus.instr), 0);
    end
    chk("g_stray_seen", 32'(busy), 0);
    ena_nxt = 1'b1;
    fetch(16'h0000);
    fetch(16'h0001);
    core_cycle(16'h0002, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
